// File: rtl/rx_pkg.sv
// Shared receive-path types and constants: packer state encoding, SERVICE length, reflected CRC-32.
package rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SERVICE = 2'd1,
      ST_PSDU    = 2'd2,
      ST_DRAIN   = 2'd3
   } rx_state_t;

   localparam int          SERVICE_BITS_DEFAULT = 16;
   localparam logic [31:0] CRC32_INIT           = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC32_POLY_REFL      = 32'hEDB8_8320;
   localparam logic [31:0] CRC32_RESIDUE_REFL   = 32'hDEBB_20E3;

   // One bit of the LSB-first (reflected) CRC-32 shift register.
   function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic data_bit);
      logic fb;
      fb = crc[0] ^ data_bit;
      return (crc >> 1) ^ (fb ? CRC32_POLY_REFL : 32'h0);
   endfunction

endpackage

// File: rtl/psdu_byte_fifo.sv
// Show-ahead FIFO of {last, byte} entries; zero-latency read, push accepted when full only with a same-cycle pop.
// Sync flush empties it; a push that cannot be accepted is silently discarded (caller flags overflow).
module psdu_byte_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_dat,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign pop_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/psdu_byte_packer.sv
// Drops SERVICE bits, packs LENGTH octets LSB-first into a FIFO to the MAC; byte valid 1 cycle after its 8th bit.
// No upstream backpressure: full FIFO without pop drops the byte (sticky Overflow). PSDU_PACKER_FCS_EN adds CRC-32 FcsOk.
module psdu_byte_packer
   import rx_pkg::*;
#(
   parameter int LENGTH_W     = 12,
   parameter int SERVICE_BITS = SERVICE_BITS_DEFAULT,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                Start,
   input  logic [LENGTH_W-1:0] Length,
   input  logic                BitIn,
   input  logic                BitValid,
   output logic [7:0]          ByteOut,
   output logic                ByteValid,
   input  logic                ByteReady,
   output logic                LastByte,
   output logic                Done,
   output logic                Busy,
   output logic                Overflow,
   output logic                FcsOk
);

   localparam int SVC_W = $clog2(SERVICE_BITS);

   rx_state_t           state;
   rx_state_t           state_nxt;
   logic [LENGTH_W-1:0] len_q;
   logic [LENGTH_W-1:0] octet_cnt;
   logic [SVC_W-1:0]    svc_cnt;
   logic [2:0]          bit_cnt;
   logic [7:0]          shift_q;
   logic [7:0]          byte_nxt;
   logic                ovf_q;
   logic                psdu_bit;
   logic                byte_done;
   logic                last_oct;
   logic                pop;
   logic                fifo_full;
   logic                fifo_empty;
   logic [8:0]          fifo_dat;

   assign byte_nxt = {BitIn, shift_q[7:1]};
   assign pop      = !fifo_empty && ByteReady;

   // Start overrides everything else, so an abort in any state restarts at SERVICE.
   always_comb begin
      state_nxt = state;
      psdu_bit  = 1'b0;
      byte_done = 1'b0;
      last_oct  = 1'b0;
      if (Start) begin
         state_nxt = ST_SERVICE;
      end else begin
         case (state)
            ST_IDLE: state_nxt = ST_IDLE;
            ST_SERVICE: begin
               if (BitValid && (svc_cnt == SVC_W'(SERVICE_BITS - 1))) begin
                  state_nxt = (len_q == '0) ? ST_DRAIN : ST_PSDU;
               end
            end
            ST_PSDU: begin
               if (BitValid) begin
                  psdu_bit = 1'b1;
                  if (bit_cnt == 3'd7) begin
                     byte_done = 1'b1;
                     last_oct  = (octet_cnt == len_q - LENGTH_W'(1));
                     if (last_oct) state_nxt = ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (fifo_empty) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state     <= ST_IDLE;
         len_q     <= '0;
         octet_cnt <= '0;
         svc_cnt   <= '0;
         bit_cnt   <= '0;
         shift_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (Start) begin
            len_q     <= Length;
            octet_cnt <= '0;
            svc_cnt   <= '0;
            bit_cnt   <= '0;
            shift_q   <= '0;
            ovf_q     <= 1'b0;
         end else begin
            if (state == ST_SERVICE && BitValid) svc_cnt <= svc_cnt + SVC_W'(1);
            if (psdu_bit) begin
               shift_q <= byte_nxt;
               bit_cnt <= bit_cnt + 3'd1;
            end
            // Octets are counted even when dropped so the frame end is still found.
            if (byte_done) octet_cnt <= octet_cnt + LENGTH_W'(1);
            if (byte_done && fifo_full && !pop) ovf_q <= 1'b1;
         end
      end
   end

   psdu_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (9)
   ) u_fifo (
      .clk      (Clock),
      .rst      (Reset),
      .flush    (Start),
      .push     (byte_done),
      .push_dat ({last_oct, byte_nxt}),
      .pop      (pop),
      .pop_dat  (fifo_dat),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign ByteValid = !fifo_empty;
   assign ByteOut   = fifo_empty ? 8'h00 : fifo_dat[7:0];
   assign LastByte  = !fifo_empty && fifo_dat[8];
   assign Done      = (state == ST_DRAIN) && fifo_empty;
   assign Busy      = (state != ST_IDLE);
   assign Overflow  = ovf_q;

`ifdef PSDU_PACKER_FCS_EN
   logic [31:0] crc_q;
   logic [31:0] crc_nxt;
   logic        fcs_q;

   assign crc_nxt = crc32_step(crc_q, BitIn);

   always_ff @(posedge Clock) begin
      if (Reset || Start) begin
         crc_q <= CRC32_INIT;
         fcs_q <= 1'b0;
      end else if (psdu_bit) begin
         crc_q <= crc_nxt;
         if (last_oct) fcs_q <= (crc_nxt == CRC32_RESIDUE_REFL);
      end
   end

   assign FcsOk = fcs_q;
`else
   assign FcsOk = 1'b0;
`endif

endmodule

// File: tb/tb_psdu_byte_packer.sv
// Directed bench for psdu_byte_packer: normal frame, zero length, overflow, abort, bit gaps, optional FCS.
module tb_psdu_byte_packer;

   logic        Clock     = 1'b0;
   logic        Reset     = 1'b1;
   logic        Start     = 1'b0;
   logic [11:0] Length    = '0;
   logic        BitIn     = 1'b0;
   logic        BitValid  = 1'b0;
   logic        ByteReady = 1'b0;
   logic [7:0]  ByteOut;
   logic        ByteValid;
   logic        LastByte;
   logic        Done;
   logic        Busy;
   logic        Overflow;
   logic        FcsOk;

   int          checks   = 0;
   int          errors   = 0;
   int          cyc      = 0;
   int          done_cnt = 0;
   int          done_cyc = 0;
   int          pop_cyc  = 0;
   int          vld_cnt  = 0;
   logic        fcs_at_done = 1'b0;
   logic [8:0]  got [$];

   always #5 Clock = ~Clock;

   psdu_byte_packer dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Start     (Start),
      .Length    (Length),
      .BitIn     (BitIn),
      .BitValid  (BitValid),
      .ByteOut   (ByteOut),
      .ByteValid (ByteValid),
      .ByteReady (ByteReady),
      .LastByte  (LastByte),
      .Done      (Done),
      .Busy      (Busy),
      .Overflow  (Overflow),
      .FcsOk     (FcsOk)
   );

   always @(posedge Clock) cyc++;

   // Outputs are stable at the falling edge; a handshake seen here pops at the next rising edge.
   always @(negedge Clock) begin
      if (ByteValid) vld_cnt++;
      if (ByteValid && ByteReady) begin
         got.push_back({LastByte, ByteOut});
         pop_cyc = cyc;
      end
      if (Done) begin
         done_cnt++;
         done_cyc = cyc;
         fcs_at_done = FcsOk;
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic send_bit(input logic b);
      BitIn    = b;
      BitValid = 1'b1;
      tick();
      BitValid = 1'b0;
      BitIn    = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) send_bit(v[i]);
   endtask

   task automatic send_service();
      for (int i = 0; i < 16; i++) send_bit(i[0]);
   endtask

   task automatic send_bit_gap(input logic b);
      for (int k = 0; k < 6 && $urandom_range(0, 1) == 1; k++) begin
         BitIn = 1'($urandom);
         tick();
      end
      send_bit(b);
   endtask

   task automatic send_byte_gap(input logic [7:0] v);
      for (int i = 0; i < 8; i++) send_bit_gap(v[i]);
   endtask

   task automatic start_frame(input logic [11:0] len);
      Start  = 1'b1;
      Length = len;
      tick();
      Start  = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget);
      int n = 0;
      while (done_cnt == d0 && n < budget) begin
         tick();
         n++;
      end
      chk("done_seen", 32'(done_cnt != d0), 1);
      repeat (2) tick();
   endtask

   function automatic logic [8:0] entry(input int i);
      if (i < got.size()) return got[i];
      return 9'h1FF;
   endfunction

   logic [7:0] fcs_frame [13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                                  8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
   logic [7:0] t5_bytes [4]   = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

   initial begin
      int base;
      int d0;
      int v0;

      // Reset state
      repeat (3) tick();
      Reset = 1'b0;
      tick();
      chk("rst_valid", 32'(ByteValid), 0);
      chk("rst_byte",  32'(ByteOut), 0);
      chk("rst_busy",  32'(Busy), 0);
      chk("rst_done",  32'(Done), 0);
      chk("rst_ovf",   32'(Overflow), 0);
      chk("rst_fcs",   32'(FcsOk), 0);

      // 1: two-byte frame
      base = got.size(); d0 = done_cnt;
      ByteReady = 1'b1;
      start_frame(12'd2);
      chk("t1_busy", 32'(Busy), 1);
      send_service();
      send_byte(8'hA5);
      send_byte(8'h3C);
      repeat (6) send_bit(1'b1);
      wait_done(d0, 40);
      chk("t1_count", 32'(got.size() - base), 2);
      chk("t1_byte0", 32'(entry(base)), 32'h0A5);
      chk("t1_byte1", 32'(entry(base + 1)), 32'h13C);
      chk("t1_done_once", 32'(done_cnt - d0), 1);
      chk("t1_done_after_pop", 32'(done_cyc > pop_cyc), 1);
      chk("t1_idle", 32'(Busy), 0);
      chk("t1_fcs_off_or_bad", 32'(fcs_at_done), 0);

      // 2: zero-length frame
      base = got.size(); d0 = done_cnt; v0 = vld_cnt;
      start_frame(12'd0);
      for (int i = 0; i < 15; i++) send_bit(i[0]);
      chk("t2_no_early_done", 32'(Done), 0);
      send_bit(1'b1);
      chk("t2_done_pulse", 32'(Done), 1);
      tick();
      chk("t2_done_gone", 32'(Done), 0);
      chk("t2_busy_low", 32'(Busy), 0);
      chk("t2_no_valid", 32'(vld_cnt - v0), 0);
      chk("t2_done_once", 32'(done_cnt - d0), 1);

      // 3: overflow with consumer stalled
      base = got.size(); d0 = done_cnt;
      ByteReady = 1'b0;
      start_frame(12'd8);
      send_service();
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      chk("t3_ovf_before", 32'(Overflow), 0);
      send_byte(8'h55);
      chk("t3_ovf_set", 32'(Overflow), 1);
      send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
      repeat (3) tick();
      chk("t3_no_done_full", 32'(Done), 0);
      chk("t3_busy", 32'(Busy), 1);
      chk("t3_head", 32'(ByteOut), 32'h11);
      ByteReady = 1'b1;
      wait_done(d0, 40);
      chk("t3_count", 32'(got.size() - base), 4);
      chk("t3_b0", 32'(entry(base)), 32'h011);
      chk("t3_b1", 32'(entry(base + 1)), 32'h022);
      chk("t3_b2", 32'(entry(base + 2)), 32'h033);
      chk("t3_b3", 32'(entry(base + 3)), 32'h044);
      chk("t3_done_once", 32'(done_cnt - d0), 1);
      chk("t3_ovf_sticky", 32'(Overflow), 1);

      // 4: abort mid-PSDU then single-byte frame
      d0 = done_cnt;
      ByteReady = 1'b0;
      start_frame(12'd6);
      chk("t4_ovf_cleared", 32'(Overflow), 0);
      send_service();
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      chk("t4_held", 32'(ByteValid), 1);
      start_frame(12'd1);
      chk("t4_flushed", 32'(ByteValid), 0);
      chk("t4_no_done", 32'(Done), 0);
      base = got.size();
      ByteReady = 1'b1;
      send_service();
      send_byte(8'h5A);
      repeat (4) send_bit(1'b0);
      wait_done(d0, 40);
      chk("t4_count", 32'(got.size() - base), 1);
      chk("t4_byte", 32'(entry(base)), 32'h15A);
      chk("t4_done_once", 32'(done_cnt - d0), 1);

      // 5: random BitValid gaps
      base = got.size(); d0 = done_cnt;
      start_frame(12'd4);
      for (int i = 0; i < 16; i++) send_bit_gap(i[0]);
      for (int i = 0; i < 4; i++) send_byte_gap(t5_bytes[i]);
      repeat (6) send_bit_gap(1'b0);
      wait_done(d0, 60);
      chk("t5_count", 32'(got.size() - base), 4);
      chk("t5_b0", 32'(entry(base)), 32'h0DE);
      chk("t5_b1", 32'(entry(base + 1)), 32'h0AD);
      chk("t5_b2", 32'(entry(base + 2)), 32'h0BE);
      chk("t5_b3", 32'(entry(base + 3)), 32'h1EF);

`ifdef PSDU_PACKER_FCS_EN
      // 6: FCS good, then one payload bit flipped
      d0 = done_cnt;
      start_frame(12'd13);
      chk("t6_fcs_cleared", 32'(FcsOk), 0);
      send_service();
      for (int i = 0; i < 13; i++) send_byte(fcs_frame[i]);
      repeat (6) send_bit(1'b0);
      wait_done(d0, 60);
      chk("t6_fcs_good", 32'(fcs_at_done), 1);
      chk("t6_fcs_held", 32'(FcsOk), 1);
      d0 = done_cnt;
      start_frame(12'd13);
      send_service();
      for (int i = 0; i < 13; i++) send_byte((i == 0) ? (fcs_frame[i] ^ 8'h01) : fcs_frame[i]);
      repeat (6) send_bit(1'b0);
      wait_done(d0, 60);
      chk("t6_fcs_bad", 32'(fcs_at_done), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
